alu_cmd_sequencer: RTL and testbench

Upstream command stage for `alu4bit`. It accepts ALU operations `{A, B, sel}` over a valid/ready handshake and buffers them in a small FIFO. It issues one operation at a time to the ALU's registered inputs, waits out the ALU latency, captures the result, and presents it downstream with a second valid/ready handshake. Results are returned in issue order with their opcode.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_cmd_fifo.sv | 57 +++++
 rtl/alu_cmd_sequencer.sv | 153 +++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU command sequencer: opcodes,
// field widths, the command word layout and the sequencing FSM states.
package alu_pkg;

  localparam int ALU_W = 4;
  localparam int SEL_W = 3;
  localparam int CMD_W = 11;

  localparam logic [SEL_W-1:0] OP_AND   = 3'b000;
  localparam logic [SEL_W-1:0] OP_OR    = 3'b001;
  localparam logic [SEL_W-1:0] OP_ADD   = 3'b010;
  localparam logic [SEL_W-1:0] OP_SUB   = 3'b011;
  localparam logic [SEL_W-1:0] OP_XOR   = 3'b100;
  localparam logic [SEL_W-1:0] OP_SHL   = 3'b101;
  localparam logic [SEL_W-1:0] OP_SHR   = 3'b110;
  localparam logic [SEL_W-1:0] OP_PASSA = 3'b111;

  typedef struct packed {
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
    logic [SEL_W-1:0] sel;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_HOLD = 2'b10
  } state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command buffer for the ALU sequencer. Head entry is readable combinationally
// so the sequencer can pop and load the ALU operands on the same edge.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int CMD_W = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [CMD_W-1:0] push_data,
  input  logic             pop,
  output logic [CMD_W-1:0] head_data,
  output logic             empty,
  output logic             in_ready
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             in_ready_q, in_ready_d;
  logic             do_push, do_pop;
  logic [CMD_W-1:0] mem_q [DEPTH];

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign in_ready  = in_ready_q;
  assign head_data = mem_q[rd_ptr_q[AW-1:0]];
  assign do_push   = push && in_ready_q;
  assign do_pop    = pop && !empty;

  // in_ready is precomputed from the next pointers so it is a plain flop output
  always_comb begin
    wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, do_pop};
    in_ready_d = !((wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                   (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      in_ready_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      in_ready_q <= in_ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Feeds queued commands one at a time to alu4bit and returns results in order.
// Define ALU_SEQ_COUNT_EN to add the done_count completed-operation counter.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ALU_W-1:0] in_a,
  input  logic [ALU_W-1:0] in_b,
  input  logic [SEL_W-1:0] in_sel,
  output logic [ALU_W-1:0] alu_a,
  output logic [ALU_W-1:0] alu_b,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [ALU_W-1:0] alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ALU_W-1:0] out_result,
  output logic [SEL_W-1:0] out_sel,
  output logic             busy
`ifdef ALU_SEQ_COUNT_EN
  ,
  output logic [7:0]       done_count
`endif
);

  cmd_t             push_cmd, head_cmd;
  logic [CMD_W-1:0] head_bits;
  logic             fifo_empty, pop;

  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [ALU_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [SEL_W-1:0] alu_sel_q, alu_sel_d;
  logic             out_valid_q, out_valid_d;
  logic [ALU_W-1:0] out_result_q, out_result_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;

  assign push_cmd = '{a: in_a, b: in_b, sel: in_sel};
  assign head_cmd = cmd_t'(head_bits);

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .CMD_W (CMD_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_valid),
    .push_data (push_cmd),
    .pop       (pop),
    .head_data (head_bits),
    .empty     (fifo_empty),
    .in_ready  (in_ready)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_sel_d    = alu_sel_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_sel_d    = out_sel_q;
    pop          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          alu_a_d   = head_cmd.a;
          alu_b_d   = head_cmd.b;
          alu_sel_d = head_cmd.sel;
          cnt_d     = 3'(ALU_LAT);
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // one extra edge beyond ALU_LAT lets the ALU's registered result settle
        if (cnt_q == 3'd0) begin
          out_result_d = alu_result;
          out_sel_d    = alu_sel_q;
          out_valid_d  = 1'b1;
          state_d      = ST_HOLD;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_sel_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sel_q    <= alu_sel_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_sel_q    <= out_sel_d;
    end
  end

`ifdef ALU_SEQ_COUNT_EN
  logic [7:0] done_count_q, done_count_d;

  always_comb begin
    done_count_d = done_count_q;
    if (out_valid_q && out_ready) begin
      done_count_d = done_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_count_q <= '0;
    end else begin
      done_count_q <= done_count_d;
    end
  end

  assign done_count = done_count_q;
`endif

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_sel    = alu_sel_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_sel    = out_sel_q;
  assign busy       = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer driving a behavioural one-cycle alu4bit.
// Define ALU_SEQ_COUNT_EN to also exercise done_count.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a, in_b;
  logic [2:0] in_sel;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_sel;
  logic [3:0] alu_result;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_result;
  logic [2:0] out_sel;
  logic       busy;
`ifdef ALU_SEQ_COUNT_EN
  logic [7:0] done_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.DEPTH(4), .ALU_LAT(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_sel     (in_sel),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_sel    (out_sel),
    .busy       (busy)
`ifdef ALU_SEQ_COUNT_EN
    ,
    .done_count (done_count)
`endif
  );

  // one-cycle registered alu4bit
  always @(posedge clk) begin
    case (alu_sel)
      3'b000:  alu_result <= alu_a & alu_b;
      3'b001:  alu_result <= alu_a | alu_b;
      3'b010:  alu_result <= alu_a + alu_b;
      3'b011:  alu_result <= alu_a - alu_b;
      3'b100:  alu_result <= alu_a ^ alu_b;
      3'b101:  alu_result <= alu_a << 1;
      3'b110:  alu_result <= alu_a >> 1;
      default: alu_result <= alu_a;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic get_result(input logic [3:0] exp_r, input logic [2:0] exp_s);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    chk("result_valid", {31'd0, out_valid}, 32'd1);
    chk("result_value", {28'd0, out_result}, {28'd0, exp_r});
    chk("result_sel", {29'd0, out_sel}, {29'd0, exp_s});
    $display("result: value=%0h sel=%0d wait=%0d", out_result, out_sel, n);
    step();
  endtask

  logic [3:0] exp_res [5];
  int pushed, got, seen_valid;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sel = '0; out_ready = 1'b1;
    repeat (3) step();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_alu_a", {28'd0, alu_a}, 32'd0);
    chk("rst_alu_b", {28'd0, alu_b}, 32'd0);
    chk("rst_alu_sel", {29'd0, alu_sel}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_result", {28'd0, out_result}, 32'd0);
    chk("rst_out_sel", {29'd0, out_sel}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);

    // single ADD 7+5
    in_valid = 1'b1; in_a = 4'd7; in_b = 4'd5; in_sel = 3'b010;
    step();
    in_valid = 1'b0;
    step();
    chk("single_alu_a", {28'd0, alu_a}, 32'd7);
    chk("single_alu_b", {28'd0, alu_b}, 32'd5);
    chk("single_alu_sel", {29'd0, alu_sel}, 32'd2);
    chk("single_busy", {31'd0, busy}, 32'd1);
    step();
    chk("single_valid_e1", {31'd0, out_valid}, 32'd0);
    step();
    chk("single_valid_e2", {31'd0, out_valid}, 32'd1);
    chk("single_result", {28'd0, out_result}, 32'hC);
    chk("single_sel", {29'd0, out_sel}, 32'd2);
    $display("single: result=%0h sel=%0d", out_result, out_sel);
    step();
    chk("single_valid_e3", {31'd0, out_valid}, 32'd0);
    chk("single_idle_busy", {31'd0, busy}, 32'd0);

    // burst of five with the consumer stalled
    out_ready = 1'b0;
    exp_res[0] = 4'h5; exp_res[1] = 4'h7; exp_res[2] = 4'hC; exp_res[3] = 4'h2; exp_res[4] = 4'h2;
    for (int i = 0; i < 5; i++) begin
      chk("burst_in_ready", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1; in_a = 4'd7; in_b = 4'd5; in_sel = 3'(i);
      step();
      $display("burst push %0d: sel=%0d in_ready=%0b", i, i, in_ready);
    end
    in_valid = 1'b0;
    chk("burst_full", {31'd0, in_ready}, 32'd0);
    step();
    step();
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_result", {28'd0, out_result}, 32'h5);
      chk("hold_sel", {29'd0, out_sel}, 32'd0);
      chk("hold_alu", {21'd0, alu_a, alu_b, alu_sel}, {21'd0, 4'd7, 4'd5, 3'd0});
      chk("hold_busy", {31'd0, busy}, 32'd1);
      chk("hold_no_pop", {31'd0, in_ready}, 32'd0);
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      get_result(exp_res[i], 3'(i));
    end

    // reset while a command is in WAIT and three remain queued
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_a = 4'(i + 1); in_b = 4'd1; in_sel = 3'b010;
      step();
    end
    in_valid = 1'b0;
    step();
    chk("midwait_alu_a", {28'd0, alu_a}, 32'd2);
    chk("midwait_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    step();
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("midrst_alu", {21'd0, alu_a, alu_b, alu_sel}, 32'd0);
    chk("midrst_out", {24'd0, out_valid, out_result, out_sel}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    $display("reset mid-WAIT: busy=%0b out_valid=%0b", busy, out_valid);
    rst_n = 1'b1;
    step();
    seen_valid = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid !== 1'b0) seen_valid++;
      step();
    end
    chk("discarded_no_valid", 32'(seen_valid), 32'd0);
    chk("discarded_busy", {31'd0, busy}, 32'd0);

    // nine SUB 0-1 to wrap the pointers
    pushed = 0; got = 0;
    for (int c = 0; c < 80; c++) begin
      in_valid = (pushed < 9); in_a = 4'd0; in_b = 4'd1; in_sel = 3'b011;
      if (in_valid && in_ready) pushed++;
      if (out_valid === 1'b1) begin
        chk("wrap_result", {28'd0, out_result}, 32'hF);
        chk("wrap_sel", {29'd0, out_sel}, 32'd3);
        got++;
        $display("wrap result %0d: value=%0h", got, out_result);
      end
      step();
    end
    in_valid = 1'b0;
    chk("wrap_pushed", 32'(pushed), 32'd9);
    chk("wrap_got", 32'(got), 32'd9);

`ifdef ALU_SEQ_COUNT_EN
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("count_reset", {24'd0, done_count}, 32'd0);
    pushed = 0; got = 0;
    for (int c = 0; c < 2000 && got < 256; c++) begin
      in_valid = (pushed < 256); in_a = 4'd3; in_b = 4'd1; in_sel = 3'b010;
      if (in_valid && in_ready) pushed++;
      if (out_valid === 1'b1) begin
        step();
        got++;
        if (got == 255) begin
          chk("count_255", {24'd0, done_count}, 32'd255);
          $display("count after 255: %0d", done_count);
        end
        if (got == 256) begin
          chk("count_wrap", {24'd0, done_count}, 32'd0);
          $display("count after 256: %0d", done_count);
        end
      end else begin
        step();
      end
    end
    in_valid = 1'b0;
    chk("count_handshakes", 32'(got), 32'd256);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
